mux_sel_stepper: RTL and testbench
==================================

# mux_sel_stepper

Upstream control stage for the 4:1 switch multiplexer. Takes a raw, bouncing, active-low pushbutton, then synchronises and debounces it. Each clean press advances a select counter whose output drives the multiplexer's select inputs in place of two slide switches. An optional auto-scan mode steps the select periodically without any button activity.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required to accept a level change (10 ms at 50 MHz); minimum 2.
- SCAN_CYCLES, 50000000: auto-scan step period in cycles; minimum 2; only used with auto-scan compiled in.
- SEL_W, 2: select width; counter range 0 to 2^SEL_W-1.

Ports:
- Clock (CLOCK_50), input, 1: the only clock; all state updates on its rising edge.
- resetn, input, 1: reset, asynchronous and active-low.
- key_n, input, 1: raw pushbutton, 0 = pressed; asynchronous to clock.
- dir, input, 1: step direction; 0 = increment, 1 = decrement.
- auto_en, input, 1: auto-scan enable; ignored when auto-scan is compiled out.
- sel, output, SEL_W: select value to the multiplexer.
- step, output, 1: one-cycle pulse on every sel change.
- key_db, output, 1: debounced pressed level, 1 = pressed.

## Operation
- Synchroniser: two flops on key_n, reset to 1 (released). After inversion, the output is `ks` (1 = pressed).
- Debounce:
  - Counter `dcnt` is cleared whenever `ks == key_db`.
  - While `ks != key_db`, `dcnt` increments each cycle.
  - When `dcnt == DEBOUNCE_CYCLES-1` and still mismatched, key_db toggles on the next edge and `dcnt` clears.
  - Any bounce back to the key_db level before that point restarts the count from 0.
- Debounce states, derived from key_db and the mismatch condition:
  - RELEASED: stable released.
  - PRESS_WAIT: counting toward pressed.
  - PRESSED: stable pressed.
  - RELEASE_WAIT: counting toward released.
  - Transitions: RELEASED→PRESS_WAIT→PRESSED→RELEASE_WAIT→RELEASED. A bounce returns PRESS_WAIT to RELEASED, and RELEASE_WAIT to PRESSED.
- Press event: the key_db 0→1 transition only. Releases never step. Holding the button does not repeat.
- Select counter:
  - On a step event, sel becomes sel+1 when dir=0, or sel−1 when dir=1, modulo 2^SEL_W.
  - Wrap-around: 3→0 going up and 0→3 going down (for SEL_W=2).
- dir is sampled on the step edge. Changing dir between steps affects only the next step.

## Timing
- Reset values: sel=0, step=0, key_db=0; synchroniser flops=1; dcnt=0; scan counter=0.
- Reset assertion clears every state immediately, including mid-debounce and mid-scan. After release, a new press needs the full debounce period again.
- Press latency, from the first cycle key_n is low at the synchroniser input and held stable: 2 cycles synchroniser plus DEBOUNCE_CYCLES cycles, then key_db=1.
- sel updates on the same edge that key_db rises. step is high for exactly that one cycle.
- Release latency is identical in structure. key_db falls and no step occurs.
- step is never high for two consecutive cycles.
- When step is high, sel already holds the new value.

## Configuration
- SEL_AUTO_SCAN_EN defined:
  - Scan counter `scnt` runs while auto_en=1 and counts 0..SCAN_CYCLES-1.
  - At terminal count it generates a step event, using dir, and wraps to 0.
  - auto_en=0 holds `scnt` at 0.
  - A button press event resets `scnt` to 0.
  - If a press event and a scan terminal count coincide, exactly one step occurs.
- SEL_AUTO_SCAN_EN undefined: no scan counter is built. auto_en is unused, and sel changes only on button presses.

## Structure
- Shared package `mux_sel_pkg`:
  - SEL_W default constant.
  - Direction encodings DIR_UP=0 and DIR_DOWN=1.
  - Debounce state enum (RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT), used for debug visibility.
- One sub-module, `key_debounce`, containing the synchroniser, dcnt and key_db, with a `press` pulse output. It is reusable for other KEY inputs.
- The top level holds the select counter, the scan counter and step generation.

## Test plan
Benches use DEBOUNCE_CYCLES=4 and SCAN_CYCLES=8.
- Clean press: key_n held low for 10 cycles from reset. key_db rises 6 cycles after the first low sample; sel goes 0→1 with a one-cycle step; release causes no step.
- Bounce: key_n low 3 cycles, high 1, low 8. Exactly one step occurs, and key_db rises 6 cycles after the final falling edge.
- Wrap-around:
  - dir=0 with 4 clean presses gives sel 1,2,3,0.
  - dir=1 from 0 with 1 press gives sel=3.
- Reset mid-operation: assert resetn=0 during PRESS_WAIT with sel=2. sel=0 and key_db=0 immediately; after release, a held press needs a full 6 cycles.
- Auto-scan (SEL_AUTO_SCAN_EN): auto_en=1, dir=0. step every 8 cycles, giving sel 1,2,3,0.
- Simultaneous events: press event coincides with scan terminal count. sel advances by exactly 1 and scnt restarts at 0.

Source files
------------

// File: rtl/mux_sel_pkg.sv
// mux_sel_pkg: shared definitions for the select-stepper slice.
//   SEL_W_DEF    default select width (4:1 mux -> 2 bits)
//   DIR_UP/DOWN  encodings of the dir input
//   db_state_t   debounce state, exported for debug visibility
package mux_sel_pkg;

  localparam int SEL_W_DEF = 2;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_t;

endpackage

// File: rtl/mux_sel_stepper_if.sv
// mux_sel_stepper_if: user-facing signals of the select stepper.
//   key_n    raw pushbutton, 0 = pressed (asynchronous)
//   dir      step direction, DIR_UP / DIR_DOWN
//   auto_en  auto-scan enable
//   sel      select value to the multiplexer
//   step     one-cycle pulse on every sel change
//   key_db   debounced pressed level, 1 = pressed
//   db_state debounce state (debug)
// Modports: master = the environment (button/switches), slave = the stepper.
interface mux_sel_stepper_if
  import mux_sel_pkg::*;
#(
  parameter int SEL_W = SEL_W_DEF
) ();

  logic             key_n;
  logic             dir;
  logic             auto_en;
  logic [SEL_W-1:0] sel;
  logic             step;
  logic             key_db;
  db_state_t        db_state;

  modport master (
    output key_n, dir, auto_en,
    input  sel, step, key_db, db_state
  );

  modport slave (
    input  key_n, dir, auto_en,
    output sel, step, key_db, db_state
  );

endinterface

// File: rtl/key_debounce.sv
// key_debounce: two-flop synchroniser plus counting debouncer for one
// active-low pushbutton. Reusable for any KEY input.
//   clk, rst_n  clock, asynchronous active-low reset
//   key_n       raw button, 0 = pressed
//   key_db      debounced level, 1 = pressed
//   press       high in the cycle before key_db rises, so a consumer that
//               registers on it updates on the same edge as key_db
//   state       debounce state for debug
module key_debounce
  import mux_sel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      key_n,
  output logic      key_db,
  output logic      press,
  output db_state_t state
);

  localparam int DCNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]        sync_q;
  logic [DCNT_W-1:0] dcnt;
  logic              ks;
  logic              mismatch;
  logic              toggle;

  assign ks       = ~sync_q[1];
  assign mismatch = (ks != key_db);
  assign toggle   = mismatch && (dcnt == DCNT_LAST);
  assign press    = toggle && !key_db;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values; blocking here would collapse the sync chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Synchroniser resets to the released level so no phantom press
      // appears as reset lifts.
      sync_q <= 2'b11;
      dcnt   <= '0;
      key_db <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], key_n};
      if (!mismatch) begin
        dcnt <= '0;
      end else if (toggle) begin
        key_db <= ~key_db;
        dcnt   <= '0;
      end else begin
        dcnt <= dcnt + DCNT_W'(1);
      end
    end
  end

  always_comb begin
    unique case ({key_db, mismatch})
      2'b00:   state = RELEASED;
      2'b01:   state = PRESS_WAIT;
      2'b10:   state = PRESSED;
      default: state = RELEASE_WAIT;
    endcase
  end

endmodule

// File: rtl/mux_sel_stepper.sv
// mux_sel_stepper: debounced pushbutton -> wrapping select counter for the
// 4:1 switch multiplexer, with optional periodic auto-scan.
//   CLOCK_50  the only clock
//   resetn    asynchronous active-low reset
//   bus       mux_sel_stepper_if.slave (key_n, dir, auto_en in;
//             sel, step, key_db, db_state out)
// Build option: define SEL_AUTO_SCAN_EN to include the auto-scan counter.
// Without it auto_en is ignored and sel moves only on button presses.
module mux_sel_stepper
  import mux_sel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SCAN_CYCLES     = 50000000,
  parameter int SEL_W           = SEL_W_DEF
) (
  input  logic               CLOCK_50,
  input  logic               resetn,
  mux_sel_stepper_if.slave   bus
);

  logic             press;
  logic             step_ev;
  logic             step_q;
  logic [SEL_W-1:0] sel_q;

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk    (CLOCK_50),
    .rst_n  (resetn),
    .key_n  (bus.key_n),
    .key_db (bus.key_db),
    .press  (press),
    .state  (bus.db_state)
  );

`ifdef SEL_AUTO_SCAN_EN
  localparam int SCNT_W = (SCAN_CYCLES > 2) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SCAN_CYCLES - 1);

  logic [SCNT_W-1:0] scnt;
  logic              scan_tc;

  assign scan_tc = bus.auto_en && (scnt == SCNT_LAST);

  // A press restarts the scan period so an auto step never lands right
  // on top of a manual one; terminal count wraps the same way.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      scnt <= '0;
    end else if (!bus.auto_en || press || scan_tc) begin
      scnt <= '0;
    end else begin
      scnt <= scnt + SCNT_W'(1);
    end
  end

  // OR-ing the sources makes a coincident press and terminal count a
  // single step.
  assign step_ev = press || scan_tc;
`else
  localparam int unused_scan_cycles = SCAN_CYCLES;
  logic unused_auto_en;
  assign unused_auto_en = bus.auto_en;
  assign step_ev        = press;
`endif

  // dir is sampled on the stepping edge itself; SEL_W-bit arithmetic
  // provides the wrap-around in both directions.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      sel_q  <= '0;
      step_q <= 1'b0;
    end else begin
      step_q <= step_ev;
      if (step_ev) begin
        sel_q <= (bus.dir == DIR_DOWN) ? sel_q - SEL_W'(1) : sel_q + SEL_W'(1);
      end
    end
  end

  assign bus.sel  = sel_q;
  assign bus.step = step_q;

endmodule

// File: tb/tb_mux_sel_stepper.sv
// tb_mux_sel_stepper: directed bench for mux_sel_stepper with
// DEBOUNCE_CYCLES=4 and SCAN_CYCLES=8. Outputs are sampled 1 time unit
// after each rising edge; inputs change at those same points.
module tb_mux_sel_stepper;
  import mux_sel_pkg::*;

  localparam int DB = 4;
  localparam int SC = 8;

  logic clk = 1'b0;
  logic resetn;
  int   vectors     = 0;
  int   miscompares = 0;
  int   step_cnt    = 0;

  always #5 clk = ~clk;

  mux_sel_stepper_if #(.SEL_W(2)) bus ();

  mux_sel_stepper #(
    .DEBOUNCE_CYCLES (DB),
    .SCAN_CYCLES     (SC),
    .SEL_W           (2)
  ) dut (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .bus      (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, counting step pulses seen at each sample point.
  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (bus.step === 1'b1) step_cnt++;
    end
  endtask

  task automatic do_reset();
    bus.key_n   = 1'b1;
    bus.dir     = DIR_UP;
    bus.auto_en = 1'b0;
    resetn      = 1'b0;
    run(2);
    resetn = 1'b1;
    step_cnt = 0;
  endtask

  // Clean press held 10 cycles then released; sel checked on the rise edge.
  task automatic press_once(input logic d, input logic [31:0] exp_sel, input string tag);
    bus.dir   = d;
    bus.key_n = 1'b0;
    run(6);
    check(tag, 32'(bus.sel), exp_sel);
    run(4);
    bus.key_n = 1'b1;
    run(8);
  endtask

  initial begin
    // ---- reset state
    bus.key_n   = 1'b1;
    bus.dir     = DIR_UP;
    bus.auto_en = 1'b0;
    resetn      = 1'b0;
    run(3);
    check("rst_sel", 32'(bus.sel), 0);
    check("rst_step", 32'(bus.step), 0);
    check("rst_key_db", 32'(bus.key_db), 0);
    check("rst_state", 32'(bus.db_state), 32'(RELEASED));
    resetn = 1'b1;
    run(2);
    step_cnt = 0;

    // ---- clean press: first low sample on edge 1, key_db rises on edge 6
    bus.key_n = 1'b0;
    run(2);
    check("clean_state_wait", 32'(bus.db_state), 32'(PRESS_WAIT));
    run(3);
    check("clean_db_e5", 32'(bus.key_db), 0);
    run(1);
    check("clean_db_e6", 32'(bus.key_db), 1);
    check("clean_sel", 32'(bus.sel), 1);
    check("clean_step", 32'(bus.step), 1);
    check("clean_state_pr", 32'(bus.db_state), 32'(PRESSED));
    run(1);
    check("clean_step_1cyc", 32'(bus.step), 0);
    run(3);
    bus.key_n = 1'b1;
    run(5);
    check("rel_db_e5", 32'(bus.key_db), 1);
    check("rel_state_wait", 32'(bus.db_state), 32'(RELEASE_WAIT));
    run(1);
    check("rel_db_e6", 32'(bus.key_db), 0);
    run(3);
    check("clean_steps", 32'(step_cnt), 1);
    check("rel_sel", 32'(bus.sel), 1);

    // ---- bounce: low 3, high 1, low 8; final low sample on edge 5
    step_cnt  = 0;
    bus.key_n = 1'b0;
    run(3);
    bus.key_n = 1'b1;
    run(1);
    bus.key_n = 1'b0;
    run(5);
    check("bounce_db_e9", 32'(bus.key_db), 0);
    run(1);
    check("bounce_db_e10", 32'(bus.key_db), 1);
    check("bounce_sel", 32'(bus.sel), 2);
    run(2);
    bus.key_n = 1'b1;
    run(8);
    check("bounce_steps", 32'(step_cnt), 1);
    check("bounce_rel_db", 32'(bus.key_db), 0);

    // ---- reset during PRESS_WAIT with sel=2
    bus.key_n = 1'b0;
    run(3);
    check("mid_state", 32'(bus.db_state), 32'(PRESS_WAIT));
    resetn = 1'b0;
    #1;
    check("mid_rst_sel", 32'(bus.sel), 0);
    check("mid_rst_db", 32'(bus.key_db), 0);
    check("mid_rst_state", 32'(bus.db_state), 32'(RELEASED));
    run(2);
    resetn   = 1'b1;
    step_cnt = 0;
    run(5);
    check("mid_db_e5", 32'(bus.key_db), 0);
    run(1);
    check("mid_db_e6", 32'(bus.key_db), 1);
    check("mid_sel", 32'(bus.sel), 1);
    run(4);
    bus.key_n = 1'b1;
    run(8);

    // ---- wrap-around: up 2,3,0 then down 3, then up again 0
    press_once(DIR_UP, 2, "up_2");
    press_once(DIR_UP, 3, "up_3");
    press_once(DIR_UP, 0, "wrap_up_0");
    press_once(DIR_DOWN, 3, "wrap_down_3");
    press_once(DIR_UP, 0, "dir_change_0");

`ifdef SEL_AUTO_SCAN_EN
    // ---- auto-scan: step every 8 cycles
    do_reset();
    bus.auto_en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      run(7);
      check("scan_quiet", 32'(bus.step), 0);
      run(1);
      check("scan_step", 32'(bus.step), 1);
      check("scan_sel", 32'(bus.sel), 32'(k % 4));
    end
    bus.auto_en = 1'b0;
    step_cnt    = 0;
    run(20);
    check("scan_off_steps", 32'(step_cnt), 0);

    // ---- press coincides with terminal count on edge 8 after auto_en
    do_reset();
    bus.auto_en = 1'b1;
    run(2);
    bus.key_n = 1'b0;
    run(6);
    check("coinc_sel", 32'(bus.sel), 1);
    check("coinc_step", 32'(bus.step), 1);
    run(1);
    check("coinc_step_1cyc", 32'(bus.step), 0);
    run(6);
    check("coinc_quiet", 32'(bus.step), 0);
    run(1);
    check("coinc_next_step", 32'(bus.step), 1);
    check("coinc_next_sel", 32'(bus.sel), 2);
    bus.auto_en = 1'b0;
    bus.key_n   = 1'b1;
    run(8);

    // ---- press restarts scnt: without restart the scan would fire on edge 9
    do_reset();
    bus.key_n = 1'b0;
    run(1);
    bus.auto_en = 1'b1;
    run(5);
    check("prst_press_step", 32'(bus.step), 1);
    check("prst_press_sel", 32'(bus.sel), 1);
    run(3);
    check("prst_no_old_tc", 32'(bus.step), 0);
    run(4);
    check("prst_quiet", 32'(bus.step), 0);
    run(1);
    check("prst_scan_step", 32'(bus.step), 1);
    check("prst_scan_sel", 32'(bus.sel), 2);
    bus.auto_en = 1'b0;
    bus.key_n   = 1'b1;
    run(8);
`else
    // ---- auto-scan compiled out: auto_en must have no effect
    bus.auto_en = 1'b1;
    step_cnt    = 0;
    run(20);
    check("noscan_steps", 32'(step_cnt), 0);
    check("noscan_sel", 32'(bus.sel), 0);
    bus.auto_en = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
